// File: rtl/audio_button_pio.sv
// audio_button_pio: Avalon-MM input PIO for front-panel buttons.
// Synchronise, debounce, capture edges, raise a maskable level irq.
module audio_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr_en = chipselect & ~write_n;

  // Two-stage synchroniser for the raw button levels
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  // Per-bit debounce: count consecutive differing cycles, glitch restarts
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Edge select and register writes; a fresh edge beats its own clear
  always_comb begin
    rise = stable_d & ~stable_q;
    fall = ~stable_d & stable_q;
    if (EDGE_TYPE == 0) begin
      det = rise;
    end else if (EDGE_TYPE == 1) begin
      det = fall;
    end else begin
      det = rise | fall;
    end
    irqmask_d = irqmask_q;
    if (wr_en && address == 2'd1) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    clr = '0;
    if (wr_en && address == 2'd3) begin
      clr = writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~clr) | det;
  end

  // Read mux, sampled every cycle regardless of chipselect
  always_comb begin
    readdata_d = '0;
    unique case (address)
      2'd0:    readdata_d = 32'(stable_q);
      2'd1:    readdata_d = 32'(irqmask_q);
      2'd2:    readdata_d = '0;
      2'd3:    readdata_d = 32'(edgecap_q);
      default: readdata_d = '0;
    endcase
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: doc/audio_button_pio.md
Name: audio_button_pio

Overview:
- Parametrised Avalon-MM input PIO for the audio player's front-panel buttons (play, stop, previous, next, ...), replacing the per-button single-bit input ports.
- Each of WIDTH inputs passes through a 2-FF synchroniser and a per-bit debouncer.
- Debounced transitions of the selected polarity are latched in an edge-capture register.
- A maskable level interrupt goes to the Nios II, so firmware no longer polls button state.

Parameters:
- WIDTH, 4: number of button inputs (1..32).
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles a synchronised input must differ from the debounced state before that state updates (10 ms at 50 MHz); minimum 1.
- EDGE_TYPE, 1: captured edge; 0 = rising, 1 = falling (active-low buttons), 2 = any.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  Avalon register word address
- chipselect  in  1  Avalon slave select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- in_port  in  WIDTH  raw asynchronous button levels
- irq  out  1  level interrupt request, active high

Behaviour:
- Reset is asynchronous, active-low (reset_n); all state uses clk only. While reset_n = 0, every register is 0:
  - sync stages, debounced state, counters, irqmask, edgecapture, readdata.
  - irq therefore reads 0 during reset.
- Synchroniser: sync1 <= in_port; sync2 <= sync1. A change at in_port is visible in sync2 after 2 rising edges.
- Debouncer, per bit i, counter width clog2(DEBOUNCE_CYCLES+1):
  - sync2[i] == stable[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync2[i] and cnt[i] <= 0.
  - Otherwise cnt[i] <= cnt[i]+1.
  - Any glitch back to the stable value restarts the count from 0.
  - The counter never wraps.
- Latency: a clean input change reaches stable after 2+DEBOUNCE_CYCLES edges and readdata one edge later.
- Edge detect, on the same edge stable updates:
  - rise[i] = stable_next & ~stable; fall[i] = ~stable_next & stable.
  - det[i] = rise, fall, or rise|fall according to EDGE_TYPE.
- Register map (word addresses):
  - 0 data, RO: zero-extended stable; writes ignored.
  - 1 irqmask, RW: bits [WIDTH-1:0].
  - 2 reserved: reads 0, writes ignored.
  - 3 edgecapture: write-1-to-clear per bit.
- Write qualification: a write takes effect when chipselect = 1 and write_n = 0 at the rising edge.
- Edgecapture update: edgecapture <= (edgecapture & ~clr) | det.
  - clr = writedata[WIDTH-1:0] on a write to address 3, else 0.
  - A new edge in the same cycle as its clear leaves the bit set (set wins).
- readdata:
  - Updated every cycle, independent of chipselect, as the zero-extended mux of the current register selected by address.
  - One-cycle read latency.
  - Bits [31:WIDTH] always 0.
- irq = |(edgecapture & irqmask), driven directly from registers with no added latency.
  - Stays asserted until firmware clears every unmasked captured bit or masks it.
- Reset mid-debounce discards the partial count; after release, stable = 0.
  - If in_port is held high through reset with EDGE_TYPE = 0 or 2, a rising edge is captured DEBOUNCE_CYCLES+2 cycles after release.
- Bits are fully independent; simultaneous events on several bits each behave as above.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1 unless stated):
- Reset state: hold reset_n = 0 with in_port = 4'hF, release at edge 0, irqmask = 0.
  - Must see readdata = 0 and irq = 0 during and after reset.
  - data (addr 0) reads 0x0000000F after edge 7.
  - edgecapture stays 0, since the transition is a rising edge.
- Clean press with interrupt:
  - Set irqmask = 4'h2.
  - Drop in_port[1] 1→0 at edge N.
  - edgecapture reads 0x2 and irq = 1 from edge N+6.
  - Write 0x2 to address 3 → irq = 0 on the next cycle.
- Bounce rejection:
  - in_port[0] toggles every 2 cycles for 20 cycles, then settles at 0.
  - stable[0] changes only once, 6 edges after settling.
  - edgecapture[0] is set exactly once.
- Masking:
  - irqmask = 0, press bit 3 → edgecapture = 0x8, irq = 0.
  - Then write irqmask = 0x8 → irq = 1 on the next cycle.
- Set-vs-clear collision:
  - Write 0x1 to address 3 on the exact edge where bit 0 detects a new falling edge.
  - edgecapture[0] remains 1.
- EDGE_TYPE = 2: press and release bit 2 → edgecapture[2] is set after each debounced transition; readdata bits [31:4] are always 0; address 2 reads 0 after a write of 0xFFFFFFFF.
